// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit (master) and the data memory (slave).
// Handshake: mem_req is held with stable mem_we/addr/be/wdata until the cycle mem_ready=1.
interface mem_access_unit_if #(
    parameter int ADDR_W = 12
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access: aligns stores, runs the req/ready handshake with a timeout,
// extends loads, stalls the pipeline until completion and flags faulted accesses.
module mem_access_unit #(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [3:0]        BE,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    mem_access_unit_if.master mem,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              done,
    output logic              err,
    output logic [1:0]        state_dbg
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    off_q;
    logic [2:0]    f3_q;
    logic          store_q;
    logic          req;
    logic          legal;
    logic [31:0]   lane;
    logic [31:0]   ext;
    logic          unused_addr;

    assign req         = MemWrite | MemRead;
    assign unused_addr = ^addr[31:ADDR_W+2];
    assign state_dbg   = state;

    // Reset gates stall so an abandoned access releases the pipeline immediately.
    assign stall = RSTn & (((state == IDLE) & req) | (state == ACCESS));

    always_comb begin
        legal = 1'b0;
        case (funct3)
            3'b000:  legal = 1'b1;
            3'b100:  legal = ~MemWrite;
            3'b001:  legal = ~addr[0];
            3'b101:  legal = ~MemWrite & ~addr[0];
            3'b010:  legal = (addr[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    assign lane = mem.mem_rdata >> {off_q, 3'b000};

    always_comb begin
        case (f3_q)
            3'b000:  ext = {{24{lane[7]}}, lane[7:0]};
            3'b100:  ext = {24'h0, lane[7:0]};
            3'b001:  ext = {{16{lane[15]}}, lane[15:0]};
            3'b101:  ext = {16'h0, lane[15:0]};
            default: ext = lane;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state         <= IDLE;
            cnt           <= '0;
            off_q         <= 2'b00;
            f3_q          <= 3'b000;
            store_q       <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_be    <= 4'h0;
            mem.mem_wdata <= 32'h0;
            load_data     <= 32'h0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (req) begin
                        off_q   <= addr[1:0];
                        f3_q    <= funct3;
                        store_q <= MemWrite;
                        if (legal) begin
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= MemWrite;
                            mem.mem_addr  <= addr[ADDR_W+1:2];
                            mem.mem_be    <= BE << addr[1:0];
                            mem.mem_wdata <= wdata << {addr[1:0], 3'b000};
                            cnt           <= CW'(1);
                            state         <= ACCESS;
                        end else begin
                            load_data <= 32'h0;
                            done      <= 1'b1;
                            err       <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                ACCESS: begin
                    // A ready on the final allowed cycle still counts as success.
                    if (mem.mem_ready || (cnt == CW'(TIMEOUT))) begin
                        mem.mem_req   <= 1'b0;
                        mem.mem_we    <= 1'b0;
                        mem.mem_addr  <= '0;
                        mem.mem_be    <= 4'h0;
                        mem.mem_wdata <= 32'h0;
                        load_data     <= (mem.mem_ready && !store_q) ? ext : 32'h0;
                        err           <= ~mem.mem_ready;
                        done          <= 1'b1;
                        state         <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, hand-written reset/back-to-back sequences,
// and randomized accesses checked against an arithmetic reference model.
module tb_mem_access_unit;
    localparam int ADDR_W  = 12;
    localparam int TIMEOUT = 4;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        MemRead, MemWrite;
    logic [3:0]  BE;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, done, err;
    logic [31:0] load_data;
    logic [1:0]  state_dbg;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] last_load = 32'h0;

    mem_access_unit_if #(.ADDR_W(ADDR_W)) mif ();

    mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .BE        (BE),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .mem       (mif),
        .stall     (stall),
        .load_data (load_data),
        .done      (done),
        .err       (err),
        .state_dbg (state_dbg)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        mr;
        logic        mw;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        int          dly;
        int          cyc;
        logic        e_err;
        logic [31:0] e_load;
        logic [31:0] e_be;
        logic [31:0] e_wd;
        logic [31:0] e_maddr;
    } vec_t;

    vec_t vt[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] be_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic model_legal(input logic mw, input logic [2:0] f3, input logic [31:0] a);
        int off = int'(a % 4);
        if (mw && !(f3 inside {3'b000, 3'b001, 3'b010})) return 1'b0;
        if (!mw && !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b0;
        if ((f3 == 3'b001 || f3 == 3'b101) && (off % 2) != 0) return 1'b0;
        if (f3 == 3'b010 && off != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        longint unsigned off  = longint'(a % 4);
        longint unsigned lane = longint'(rd) / (64'd1 << (8 * off));
        longint unsigned b    = lane % 256;
        longint unsigned h    = lane % 65536;
        case (f3)
            3'b000:  return 32'((b >= 128) ? b + 64'hFFFFFF00 : b);
            3'b100:  return 32'(b);
            3'b001:  return 32'((h >= 32768) ? h + 64'hFFFF0000 : h);
            3'b101:  return 32'(h);
            3'b010:  return rd;
            default: return 32'h0;
        endcase
    endfunction

    task automatic idle_cycle();
        @(posedge CLK); #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        mif.mem_ready = 1'($urandom_range(0, 1));
        @(negedge CLK);
        check("idle_stall", {31'h0, stall}, 32'h0);
        check("idle_req", {31'h0, mif.mem_req}, 32'h0);
        check("idle_load_hold", load_data, last_load);
    endtask

    task automatic run_access(input string tag, input vec_t v);
        int  n = 0;
        int  req_cycles = 0;
        logic got = 1'b0;
        @(posedge CLK); #1;
        MemRead  = v.mr;
        MemWrite = v.mw;
        BE       = be_of(v.f3);
        funct3   = v.f3;
        addr     = v.a;
        wdata    = v.wd;
        mif.mem_rdata = v.rd;
        mif.mem_ready = 1'b0;
        @(negedge CLK);
        check({tag, "_stall_c0"}, {31'h0, stall}, 32'h1);
        while (!got && n < 40) begin
            n++;
            @(posedge CLK); #1;
            mif.mem_ready = (v.dly > 0 && n == v.dly) ? 1'b1 : 1'b0;
            @(negedge CLK);
            if (mif.mem_req) req_cycles++;
            if (n == 1 && v.cyc > 1) begin
                check({tag, "_we"}, {31'h0, mif.mem_we}, {31'h0, v.mw});
                check({tag, "_maddr"}, {20'h0, mif.mem_addr}, v.e_maddr);
                check({tag, "_be"}, {28'h0, mif.mem_be}, v.e_be);
                check({tag, "_wdata"}, mif.mem_wdata, v.e_wd);
            end
            if (done) begin
                got = 1'b1;
                check({tag, "_done_cycle"}, n, v.cyc);
                check({tag, "_err"}, {31'h0, err}, {31'h0, v.e_err});
                check({tag, "_load"}, load_data, v.e_load);
                check({tag, "_stall_done"}, {31'h0, stall}, 32'h0);
                last_load = v.e_load;
            end else begin
                check({tag, "_stall_wait"}, {31'h0, stall}, 32'h1);
            end
        end
        if (!got) check({tag, "_done_seen"}, 32'h0, 32'h1);
        check({tag, "_req_cycles"}, req_cycles, v.cyc - 1);
    endtask

    function automatic vec_t model_vec(input logic mr, input logic mw, input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] wd,
                                       input logic [31:0] rd, input int dly);
        vec_t v;
        longint unsigned off = longint'(a % 4);
        v.mr = mr; v.mw = mw; v.f3 = f3; v.a = a; v.wd = wd; v.rd = rd; v.dly = dly;
        v.e_be    = 32'((longint'(be_of(f3)) * (64'd1 << off)) % 16);
        v.e_wd    = 32'((longint'(wd) * (64'd1 << (8 * off))) % (64'd1 << 32));
        v.e_maddr = 32'((longint'(a) / 4) % (64'd1 << ADDR_W));
        if (!model_legal(mw, f3, a)) begin
            v.cyc = 1; v.e_err = 1'b1; v.e_load = 32'h0;
        end else if (dly >= 1 && dly <= TIMEOUT) begin
            v.cyc = dly + 1; v.e_err = 1'b0; v.e_load = mw ? 32'h0 : model_load(f3, a, rd);
        end else begin
            v.cyc = TIMEOUT + 1; v.e_err = 1'b1; v.e_load = 32'h0;
        end
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //      mr    mw    f3      addr           wdata          rdata          dly cyc err   load           be     wdata          maddr
        vt[0]  = '{1'b1, 1'b1, 3'b000, 32'h00000103, 32'h000000A5, 32'h0,         1, 2, 1'b0, 32'h0,         32'h8, 32'hA5000000, 32'h040};
        vt[1]  = '{1'b1, 1'b0, 3'b000, 32'h00000202, 32'h0,        32'h80FF7F01, 1, 2, 1'b0, 32'hFFFFFFFF, 32'h4, 32'h0,        32'h080};
        vt[2]  = '{1'b1, 1'b0, 3'b100, 32'h00000202, 32'h0,        32'h80FF7F01, 1, 2, 1'b0, 32'h000000FF, 32'h4, 32'h0,        32'h080};
        vt[3]  = '{1'b1, 1'b0, 3'b001, 32'h00000202, 32'h0,        32'h80FF7F01, 1, 2, 1'b0, 32'hFFFF80FF, 32'hC, 32'h0,        32'h080};
        vt[4]  = '{1'b1, 1'b0, 3'b101, 32'h00000202, 32'h0,        32'h80FF7F01, 2, 3, 1'b0, 32'h000080FF, 32'hC, 32'h0,        32'h080};
        vt[5]  = '{1'b1, 1'b0, 3'b010, 32'h00000006, 32'h0,        32'h0,         1, 1, 1'b1, 32'h0,         32'h0, 32'h0,        32'h0};
        vt[6]  = '{1'b1, 1'b0, 3'b010, 32'h00000010, 32'h0,        32'hDEADBEEF, 0, 5, 1'b1, 32'h0,         32'hF, 32'h0,        32'h004};
        vt[7]  = '{1'b1, 1'b0, 3'b010, 32'h00000010, 32'h0,        32'h12345678, 4, 5, 1'b0, 32'h12345678, 32'hF, 32'h0,        32'h004};
        vt[8]  = '{1'b0, 1'b1, 3'b001, 32'h00000002, 32'h0000BEEF, 32'h0,         2, 3, 1'b0, 32'h0,         32'hC, 32'hBEEF0000, 32'h000};
        vt[9]  = '{1'b1, 1'b1, 3'b100, 32'h00000000, 32'h0,        32'h0,         1, 1, 1'b1, 32'h0,         32'h0, 32'h0,        32'h0};
        vt[10] = '{1'b1, 1'b0, 3'b001, 32'h00000201, 32'h0,        32'h0,         1, 1, 1'b1, 32'h0,         32'h0, 32'h0,        32'h0};
        vt[11] = '{1'b1, 1'b0, 3'b011, 32'h00000000, 32'h0,        32'h0,         1, 1, 1'b1, 32'h0,         32'h0, 32'h0,        32'h0};
        vt[12] = '{1'b1, 1'b0, 3'b000, 32'h00000003, 32'h0,        32'h7F000000, 3, 4, 1'b0, 32'h0000007F, 32'h8, 32'h0,        32'h000};

        RSTn = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; BE = 4'h0; funct3 = 3'h0;
        addr = 32'h0; wdata = 32'h0; mif.mem_ready = 1'b0; mif.mem_rdata = 32'h0;
        #12;
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_req", {31'h0, mif.mem_req}, 32'h0);
        check("rst_we", {31'h0, mif.mem_we}, 32'h0);
        check("rst_done_err", {30'h0, done, err}, 32'h0);
        check("rst_bus", {20'h0, mif.mem_addr} | {28'h0, mif.mem_be} | mif.mem_wdata, 32'h0);
        check("rst_load", load_data, 32'h0);
        check("rst_state", {30'h0, state_dbg}, 32'h0);
        @(negedge CLK);
        RSTn = 1'b1;
        idle_cycle();

        for (int i = 0; i < 13; i++) begin
            run_access($sformatf("vec%0d", i), vt[i]);
            idle_cycle();
        end

        // Reset while the access is outstanding.
        @(posedge CLK); #1;
        MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; BE = 4'hF; addr = 32'h40;
        mif.mem_ready = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #2;
        check("mid_req_before", {31'h0, mif.mem_req}, 32'h1);
        RSTn = 1'b0;
        #1;
        check("mid_rst_req", {31'h0, mif.mem_req}, 32'h0);
        check("mid_rst_stall", {31'h0, stall}, 32'h0);
        check("mid_rst_done", {31'h0, done}, 32'h0);
        MemRead = 1'b0;
        last_load = 32'h0;
        @(negedge CLK);
        RSTn = 1'b1;
        run_access("after_rst", model_vec(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h00000055, 1));

        // Back-to-back store then load, no idle gap.
        idle_cycle();
        run_access("b2b_sw", model_vec(1'b1, 1'b1, 3'b010, 32'h20, 32'h11223344, 32'h0, 1));
        run_access("b2b_lw", model_vec(1'b1, 1'b0, 3'b010, 32'h24, 32'h0, 32'hCAFEF00D, 1));
        idle_cycle();

        for (int i = 0; i < 60; i++) begin
            logic st = 1'($urandom_range(0, 1));
            logic mr = st ? 1'($urandom_range(0, 1)) : 1'b1;
            run_access($sformatf("rnd%0d", i),
                       model_vec(mr, st, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                                 $urandom_range(0, 6)));
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
